multi_lane_serializer: RTL and testbench

- Parametrised successor of the single-lane TMDS serializer.
- Converts NUM_LANES parallel words of DATA_W bits into NUM_LANES serial streams, emitting BITS_PER_CLK bits per lane per clock. BITS_PER_CLK=2 feeds a DDR output primitive.
- Adds a valid/ready word handshake, selectable bit order, idle-word substitution with an underflow flag, and a frame strobe.
- Sits between the TMDS encoders and the output buffers/ODDR cells, clocked by the serial (or half-serial) clock.

---
 rtl/serializer_pkg.sv | 20 ++
 rtl/serializer_lane.sv | 52 +++++
 rtl/multi_lane_serializer.sv | 97 +++++++++
 tb/tb_multi_lane_serializer.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/serializer_pkg.sv
// Shared constants and helpers for the multi-lane serializer.
package serializer_pkg;

  // Default TMDS word width and the four TMDS control tokens (C1C0 = 00..11).
  localparam int unsigned TmdsDataW = 10;
  localparam logic [9:0] TmdsCtrl00 = 10'b1101010100;
  localparam logic [9:0] TmdsCtrl01 = 10'b0010101011;
  localparam logic [9:0] TmdsCtrl10 = 10'b0101010100;
  localparam logic [9:0] TmdsCtrl11 = 10'b1010101011;
  localparam logic [9:0] TmdsIdleWord = TmdsCtrl00;

  // Three lanes for a standard TMDS link (blue/green/red).
  localparam int unsigned DefaultNumLanes = 3;

  // Width of a counter covering word_cyc states, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned word_cyc);
    return (word_cyc > 1) ? $clog2(word_cyc) : 1;
  endfunction

endpackage

// File: rtl/serializer_lane.sv
// One serializer lane: shift register plus registered output bit selection.
module serializer_lane #(
  parameter int unsigned DATA_W       = 10,
  parameter int unsigned BITS_PER_CLK = 1,
  parameter int unsigned MSB_FIRST    = 0
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    load_i,
  input  logic                    en_i,
  input  logic [DATA_W-1:0]       word_i,
  output logic [BITS_PER_CLK-1:0] bits_o
);

  logic [DATA_W-1:0]       shift_q, shift_d;
  logic [BITS_PER_CLK-1:0] bits_q, bits_d;

  // Next shift-register value: load a new word or shift out BITS_PER_CLK bits.
  always_comb begin
    shift_d = shift_q;
    if (load_i) begin
      shift_d = word_i;
    end else if (MSB_FIRST != 0) begin
      shift_d = shift_q << BITS_PER_CLK;
    end else begin
      shift_d = shift_q >> BITS_PER_CLK;
    end
  end

  // Output bits come from the next shift value so a freshly loaded word shows
  // its first bits right after the loading edge; bit 0 is earliest in time.
  always_comb begin
    bits_d = '0;
    for (int unsigned b = 0; b < BITS_PER_CLK; b++) begin
      bits_d[b] = (MSB_FIRST != 0) ? shift_d[DATA_W-1-b] : shift_d[b];
    end
  end

  // State update; a disabled lane (bitslip stall) holds both registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      shift_q <= '0;
      bits_q  <= '0;
    end else if (en_i) begin
      shift_q <= shift_d;
      bits_q  <= bits_d;
    end
  end

  assign bits_o = bits_q;

endmodule

// File: rtl/multi_lane_serializer.sv
// Multi-lane parallel-to-serial converter with a shared word counter.
// Optional feature: define SERIALIZER_BITSLIP_EN to let slip_i stall one clock.
module multi_lane_serializer
  import serializer_pkg::*;
#(
  parameter int unsigned NUM_LANES    = DefaultNumLanes,
  parameter int unsigned DATA_W       = TmdsDataW,
  parameter int unsigned BITS_PER_CLK = 1,
  parameter int unsigned MSB_FIRST    = 0,
  parameter logic [DATA_W-1:0] IDLE_WORD = TmdsIdleWord
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [NUM_LANES*DATA_W-1:0]       data_i,
  input  logic                              valid_i,
  output logic                              ready_o,
  input  logic                              slip_i,
  input  logic                              clear_i,
  output logic [NUM_LANES*BITS_PER_CLK-1:0] data_o,
  output logic                              frame_o,
  output logic                              underflow_o
);

  localparam int unsigned WordCyc = DATA_W / BITS_PER_CLK;
  localparam int unsigned CntW    = cnt_width(WordCyc);
  localparam logic [CntW-1:0] CntLast = CntW'(WordCyc - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            load;
  logic            stall;
  logic            en;
  logic            frame_q;
  logic            underflow_q, underflow_d;

  assign load = (cnt_q == CntLast);

`ifdef SERIALIZER_BITSLIP_EN
  // A slip outside a load cycle freezes the whole serializer for one clock.
  assign stall = slip_i & ~load;
`else
  logic unused_slip;
  assign unused_slip = slip_i;
  assign stall       = 1'b0;
`endif

  assign en = ~stall;

  // Word counter next state and sticky underflow flag (set beats clear).
  always_comb begin
    cnt_d = cnt_q;
    if (en) begin
      cnt_d = load ? '0 : cnt_q + CntW'(1);
    end
    underflow_d = underflow_q;
    if (load && !valid_i) begin
      underflow_d = 1'b1;
    end else if (clear_i) begin
      underflow_d = 1'b0;
    end
  end

  // Counter, frame strobe and underflow registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q       <= '0;
      frame_q     <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      frame_q     <= load;
      underflow_q <= underflow_d;
    end
  end

  assign ready_o     = load;
  assign frame_o     = frame_q;
  assign underflow_o = underflow_q;

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    logic [DATA_W-1:0] word;
    assign word = valid_i ? data_i[l*DATA_W +: DATA_W] : IDLE_WORD;

    serializer_lane #(
      .DATA_W      (DATA_W),
      .BITS_PER_CLK(BITS_PER_CLK),
      .MSB_FIRST   (MSB_FIRST)
    ) u_lane (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .load_i(load),
      .en_i  (en),
      .word_i(word),
      .bits_o(data_o[l*BITS_PER_CLK +: BITS_PER_CLK])
    );
  end

endmodule

// File: tb/tb_multi_lane_serializer.sv
// Randomised self-checking bench: two serializer configurations against a
// word/bit-position reference model.
module tb_multi_lane_serializer;

  localparam logic [9:0] Idle = 10'b1101010100;

  logic        clk = 1'b0;
  logic        rst, valid, slip, clear;
  logic [29:0] data;
  logic [2:0]  d0;
  logic [5:0]  d1;
  logic        rdy0, rdy1, fr0, fr1, uf0, uf1;

  int n_checks = 0;
  int n_errors = 0;

  // Model state, index 0: 1 bit/clk LSB-first; index 1: 2 bits/clk MSB-first.
  int         bpc[2] = '{1, 2};
  int         msb[2] = '{0, 1};
  int         wc[2]  = '{10, 5};
  int         ph[2];
  int         bitpos[2];
  logic       frame_m[2];
  logic       uf_m[2];
  logic [9:0] cur[2][3];

  always #5 clk = ~clk;

  multi_lane_serializer #(
    .NUM_LANES(3), .DATA_W(10), .BITS_PER_CLK(1), .MSB_FIRST(0), .IDLE_WORD(Idle)
  ) dut0 (
    .clk_i(clk), .rst_i(rst), .data_i(data), .valid_i(valid), .ready_o(rdy0),
    .slip_i(slip), .clear_i(clear), .data_o(d0), .frame_o(fr0), .underflow_o(uf0)
  );

  multi_lane_serializer #(
    .NUM_LANES(3), .DATA_W(10), .BITS_PER_CLK(2), .MSB_FIRST(1), .IDLE_WORD(Idle)
  ) dut1 (
    .clk_i(clk), .rst_i(rst), .data_i(data), .valid_i(valid), .ready_o(rdy1),
    .slip_i(slip), .clear_i(clear), .data_o(d1), .frame_o(fr1), .underflow_o(uf1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // Lane bits expected on data_o: transmission index i of the current word
  // maps to word bit i (LSB-first) or bit 9-i (MSB-first).
  function automatic logic [5:0] exp_bits(input int m);
    logic [5:0] r;
    int         i;
    r = '0;
    for (int l = 0; l < 3; l++) begin
      for (int b = 0; b < bpc[m]; b++) begin
        i = bitpos[m] * bpc[m] + b;
        if (i < 10) r[l*bpc[m] + b] = cur[m][l][(msb[m] != 0) ? 9 - i : i];
      end
    end
    return r;
  endfunction

  // Advance the model by one clock edge using the current inputs.
  task automatic model_edge();
    logic ld, stall;
    for (int m = 0; m < 2; m++) begin
      if (rst) begin
        ph[m] = 0; bitpos[m] = 0; frame_m[m] = 1'b0; uf_m[m] = 1'b0;
        for (int l = 0; l < 3; l++) cur[m][l] = '0;
      end else begin
        ld    = (ph[m] == wc[m] - 1);
        stall = 1'b0;
`ifdef SERIALIZER_BITSLIP_EN
        stall = slip && !ld;
`endif
        if (ld && !valid) uf_m[m] = 1'b1;
        else if (clear)   uf_m[m] = 1'b0;
        frame_m[m] = ld;
        if (!stall) begin
          if (ld) begin
            for (int l = 0; l < 3; l++) cur[m][l] = valid ? data[l*10 +: 10] : Idle;
            bitpos[m] = 0;
            ph[m]     = 0;
          end else begin
            ph[m]++;
            bitpos[m]++;
          end
        end
      end
    end
  endtask

  // One clock: check ready before the edge, then registered outputs after it.
  task automatic step();
    check("ready0", 32'(rdy0), 32'(ph[0] == wc[0] - 1));
    check("ready1", 32'(rdy1), 32'(ph[1] == wc[1] - 1));
    model_edge();
    @(posedge clk);
    #1;
    check("data0", 32'(d0), 32'(exp_bits(0) & 6'h07));
    check("data1", 32'(d1), 32'(exp_bits(1)));
    check("frame0", 32'(fr0), 32'(frame_m[0]));
    check("frame1", 32'(fr1), 32'(frame_m[1]));
    check("uflow0", 32'(uf0), 32'(uf_m[0]));
    check("uflow1", 32'(uf1), 32'(uf_m[1]));
  endtask

  initial begin
    rst = 1'b1; valid = 1'b0; slip = 1'b0; clear = 1'b0; data = '0;
    repeat (2) begin
      model_edge();
      @(posedge clk);
      #1;
    end
    step();

    // Continuous valid words, lanes {2AA, 000, 3FF}.
    rst = 1'b0; valid = 1'b1; data = {10'h2AA, 10'h000, 10'h3FF};
    repeat (40) step();

    // Underflow, stays sticky, then a clear pulse.
    valid = 1'b0;
    repeat (12) step();
    valid = 1'b1;
    repeat (15) step();
    clear = 1'b1; step(); clear = 1'b0;
    repeat (10) step();

    // clear held across an underflowing load: set wins.
    valid = 1'b0; clear = 1'b1;
    repeat (12) step();
    clear = 1'b0; valid = 1'b1;
    data = {10'h201, 10'h201, 10'h201};
    repeat (20) step();

    // Reset in the middle of a word.
    for (int i = 0; i < 20 && ph[0] != 4; i++) step();
    rst = 1'b1; step(); rst = 1'b0;
    repeat (25) step();

    // Slip mid-word, then slip on a load cycle.
    for (int i = 0; i < 20 && ph[0] != 3; i++) step();
    slip = 1'b1; step(); slip = 1'b0;
    repeat (25) step();
    for (int i = 0; i < 20 && ph[0] != 9; i++) step();
    slip = 1'b1; step(); slip = 1'b0;
    repeat (12) step();

    // Randomised traffic.
    repeat (3000) begin
      data  = 30'($urandom);
      valid = ($urandom_range(9) != 0);
      clear = ($urandom_range(19) == 0);
      slip  = ($urandom_range(7) == 0);
      rst   = ($urandom_range(149) == 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
